// File: rtl/blackjack_pkg.sv
// Shared defaults, FSM encoding and value-wrap helper for the BlackJack card source.
package blackjack_pkg;

    localparam int DEF_VAL_MIN    = 1;
    localparam int DEF_VAL_MAX    = 10;
    localparam int DEF_COPIES     = 4;
    localparam int DEF_TOP_COPIES = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    function automatic int next_val(input int v, input int vmin, input int vmax);
        return (v >= vmax) ? vmin : v + 1;
    endfunction

endpackage

// File: rtl/card_deal_counter_range_counter.sv
// MIN..MAX wrapping counter with enable; free-running entropy index for the dealer.
module range_counter
    import blackjack_pkg::*;
#(
    parameter int MIN = DEF_VAL_MIN,
    parameter int MAX = DEF_VAL_MAX,
    parameter int W   = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Index register: advances while enabled, wraps MAX back to MIN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= W'(MIN);
        end else if (enable) begin
            count_r <= W'(next_val(int'(count_r), MIN, MAX));
        end
    end

    assign count = count_r;

endmodule

// File: rtl/card_deal_counter.sv
// Card source: samples the free-running index on draw, skips exhausted values,
// tracks copies dealt per value and reports deck exhaustion.
module card_deal_counter
    import blackjack_pkg::*;
#(
    parameter int VAL_MIN    = DEF_VAL_MIN,
    parameter int VAL_MAX    = DEF_VAL_MAX,
    parameter int WIDTH      = 5,
    parameter int COPIES     = DEF_COPIES,
    parameter int TOP_COPIES = DEF_TOP_COPIES,
    localparam int TOTAL     = (VAL_MAX - VAL_MIN) * COPIES + TOP_COPIES,
    localparam int CW        = $clog2(TOTAL + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             draw,
    input  logic             shuffle,
    output logic [WIDTH-1:0] card,
    output logic             card_valid,
    output logic             busy,
    output logic             deck_empty,
    output logic [CW-1:0]    cards_left,
    output logic             draw_err
);

    localparam int NV = VAL_MAX - VAL_MIN + 1;
    localparam int UW = $clog2(TOP_COPIES + 1);

    function automatic logic [UW-1:0] limit_of(input int i);
        return (i == NV - 1) ? UW'(TOP_COPIES) : UW'(COPIES);
    endfunction

    logic [WIDTH-1:0] cnt_s;
    logic [UW-1:0]    used_r [NV];
    state_t           state_r, state_s;
    logic [WIDTH-1:0] probe_r, probe_s;
    logic [WIDTH-1:0] card_r, card_s;
    logic             card_valid_r, card_valid_s;
    logic             busy_r, busy_s;
    logic             deck_empty_r, deck_empty_s;
    logic [CW-1:0]    cards_left_r, cards_left_s;
    logic             draw_err_r, draw_err_s;
    logic             avail_s;
    logic             deal_s;

    range_counter #(.MIN(VAL_MIN), .MAX(VAL_MAX), .W(WIDTH)) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .count  (cnt_s)
    );

    // Is the value currently under the probe still available in the deck?
    always_comb begin
        avail_s = 1'b0;
        for (int i = 0; i < NV; i++) begin
            avail_s = avail_s | ((probe_r == WIDTH'(VAL_MIN + i)) && (used_r[i] < limit_of(i)));
        end
    end

    // Next-state and next-output logic for the draw FSM.
    always_comb begin
        state_s      = state_r;
        probe_s      = probe_r;
        card_s       = card_r;
        card_valid_s = 1'b0;
        busy_s       = busy_r;
        deck_empty_s = deck_empty_r;
        cards_left_s = cards_left_r;
        draw_err_s   = 1'b0;
        deal_s       = 1'b0;
        if (shuffle) begin
            state_s      = IDLE;
            busy_s       = 1'b0;
            cards_left_s = CW'(TOTAL);
            deck_empty_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (draw && !deck_empty_r) begin
                        probe_s = cnt_s;
                        busy_s  = 1'b1;
                        state_s = SEARCH;
                    end else if (draw) begin
                        draw_err_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                SEARCH: begin
                    // deck_empty low on entry guarantees the scan reaches an available value
                    if (avail_s) begin
                        deal_s       = 1'b1;
                        cards_left_s = cards_left_r - CW'(1);
                        deck_empty_s = (cards_left_r == CW'(1));
                        card_s       = probe_r;
                        card_valid_s = 1'b1;
                        busy_s       = 1'b0;
                        state_s      = IDLE;
                    end else begin
                        probe_s = WIDTH'(next_val(int'(probe_r), VAL_MIN, VAL_MAX));
                    end
                end
                default: begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            probe_r      <= WIDTH'(VAL_MIN);
            card_r       <= '0;
            card_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            deck_empty_r <= 1'b0;
            cards_left_r <= CW'(TOTAL);
            draw_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            probe_r      <= probe_s;
            card_r       <= card_s;
            card_valid_r <= card_valid_s;
            busy_r       <= busy_s;
            deck_empty_r <= deck_empty_s;
            cards_left_r <= cards_left_s;
            draw_err_r   <= draw_err_s;
        end
    end

    // Per-value dealt counters: cleared by shuffle, at most one increment per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NV; i++) used_r[i] <= '0;
        end else if (shuffle) begin
            for (int i = 0; i < NV; i++) used_r[i] <= '0;
        end else if (deal_s) begin
            for (int i = 0; i < NV; i++) begin
                if (probe_r == WIDTH'(VAL_MIN + i)) used_r[i] <= used_r[i] + UW'(1);
            end
        end
    end

    assign card       = card_r;
    assign card_valid = card_valid_r;
    assign busy       = busy_r;
    assign deck_empty = deck_empty_r;
    assign cards_left = cards_left_r;
    assign draw_err   = draw_err_r;

endmodule
